fifo_drain: RTL and testbench

Pull-side consumer for the CGRA's 32-entry D_FIFO read port. It accepts a start command with a word count, then issues one-cycle read requests on the FIFO's request/valid read interface, retrying while the FIFO is empty. Each returned word is forwarded to a downstream ready/valid stream, and completion is signalled when the programmed count has been delivered. It sits between a PE output FIFO and the next consumer (store unit or routing switch).

---
 rtl/fifo_drain_pkg.sv | 17 +
 rtl/fifo_drain_sum.sv | 21 ++
 rtl/fifo_drain.sv | 104 ++++++++++
 tb/tb_fifo_drain.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_drain_pkg.sv
// Shared types and default widths for the fifo_drain block.
package fifo_drain_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int LEN_W_DEF  = 16;

  // One FIFO read attempt is REQ then WAIT.
  // OUT holds the captured word until the downstream accepts it.
  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    OUT,
    DONE
  } state_t;

endpackage

// File: rtl/fifo_drain_sum.sv
// Modulo-2^DATA_W accumulator with synchronous clear and add-enable.
// Used by fifo_drain only when FIFO_DRAIN_SUM_EN is defined.
module fifo_drain_sum #(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] sum
);

  // Clear has priority, so a new transfer always starts from zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)   sum <= '0;
    else if (clr) sum <= '0;
    else if (en)  sum <= sum + din;
  end

endmodule

// File: rtl/fifo_drain.sv
// fifo_drain: pull-side consumer for a request/valid FIFO read port.
// It forwards a programmed number of words to a ready/valid stream.
// Optional feature: define FIFO_DRAIN_SUM_EN to add the io_sum output.
// io_sum is a running sum of every word delivered in the current transfer.
module fifo_drain
  import fifo_drain_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_start,
  input  logic [LEN_W-1:0]  io_len,
  input  logic [DATA_W-1:0] io_fifo_dout,
  input  logic              io_fifo_dout_v,
  output logic              io_fifo_dout_r,
  output logic [DATA_W-1:0] io_out_data,
  output logic              io_out_v,
  input  logic              io_out_r,
  output logic              io_busy,
  output logic              io_done,
  output logic [LEN_W-1:0]  io_count
`ifdef FIFO_DRAIN_SUM_EN
  ,
  output logic [DATA_W-1:0] io_sum
`endif
);

  state_t           state, state_nxt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] count_inc;
  logic             start_ok;
  logic             handshake;

  assign start_ok  = (state == IDLE) && io_start;
  assign handshake = (state == OUT) && io_out_r;
  assign count_inc = io_count + LEN_W'(1);

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic. The FIFO valid input is only looked at in WAIT.
  always_comb begin
    // NOTE: the default comes first, so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE: if (io_start) state_nxt = (io_len != '0) ? REQ : DONE;
      REQ:  state_nxt = WAIT;
      WAIT: state_nxt = io_fifo_dout_v ? OUT : REQ;
      OUT:  if (io_out_r) state_nxt = (count_inc == len_q) ? DONE : REQ;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control outputs are registered from the next state.
  // This keeps them cycle-aligned with the state they belong to.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      io_fifo_dout_r <= 1'b0;
      io_out_v       <= 1'b0;
      io_busy        <= 1'b0;
      io_done        <= 1'b0;
    end else begin
      io_fifo_dout_r <= (state_nxt == REQ);
      io_out_v       <= (state_nxt == OUT);
      io_busy        <= (state_nxt != IDLE);
      io_done        <= (state_nxt == DONE);
    end
  end

  // Datapath: length latch, word capture, delivered-word counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      len_q       <= '0;
      io_count    <= '0;
      io_out_data <= '0;
    end else begin
      if (start_ok) begin
        len_q    <= io_len;
        io_count <= '0;
      end
      if ((state == WAIT) && io_fifo_dout_v) io_out_data <= io_fifo_dout;
      if (handshake) io_count <= count_inc;
    end
  end

`ifdef FIFO_DRAIN_SUM_EN
  fifo_drain_sum #(.DATA_W(DATA_W)) u_sum (
    .clock (clock),
    .reset (reset),
    .clr   (start_ok),
    .en    (handshake),
    .din   (io_out_data),
    .sum   (io_sum)
  );
`endif

endmodule

// File: tb/tb_fifo_drain.sv
// Self-checking bench for fifo_drain.
// A queue-based FIFO model feeds the read port.
// Expected words go into a scoreboard queue when they are loaded, and are popped on each downstream handshake.
module tb_fifo_drain;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_start = 1'b0;
  logic [15:0] io_len = '0;
  logic [31:0] io_fifo_dout;
  logic        io_fifo_dout_v;
  logic        io_fifo_dout_r;
  logic [31:0] io_out_data;
  logic        io_out_v;
  logic        io_out_r = 1'b0;
  logic        io_busy;
  logic        io_done;
  logic [15:0] io_count;
`ifdef FIFO_DRAIN_SUM_EN
  logic [31:0] io_sum;
`endif

  int          pass_cnt  = 0;
  int          total_cnt = 0;
  int          req_cnt   = 0;
  logic [31:0] fifo_q[$];
  logic [31:0] exp_q[$];

  fifo_drain dut (
    .clock          (clock),
    .reset          (reset),
    .io_start       (io_start),
    .io_len         (io_len),
    .io_fifo_dout   (io_fifo_dout),
    .io_fifo_dout_v (io_fifo_dout_v),
    .io_fifo_dout_r (io_fifo_dout_r),
    .io_out_data    (io_out_data),
    .io_out_v       (io_out_v),
    .io_out_r       (io_out_r),
    .io_busy        (io_busy),
    .io_done        (io_done),
    .io_count       (io_count)
`ifdef FIFO_DRAIN_SUM_EN
    ,
    .io_sum         (io_sum)
`endif
  );

  always #5 clock = ~clock;

  // FIFO model: a request returns data the next cycle when the FIFO is non-empty.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      io_fifo_dout_v <= 1'b0;
      io_fifo_dout   <= '0;
    end else begin
      io_fifo_dout_v <= 1'b0;
      if (io_fifo_dout_r) begin
        req_cnt <= req_cnt + 1;
        if (fifo_q.size() > 0) begin
          io_fifo_dout   <= fifo_q.pop_front();
          io_fifo_dout_v <= 1'b1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic test_reset();
    logic [51:0] obs;
    @(negedge clock);
    obs = {io_fifo_dout_r, io_out_v, io_busy, io_done, io_count, io_out_data};
    total_cnt++;
    if (obs !== '0) $display("FAIL reset_outputs: got %h expected 0", obs);
    else pass_cnt++;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    total_cnt++;
    if ({io_busy, io_fifo_dout_r} !== 2'b00)
      $display("FAIL idle_after_reset: busy/req %b expected 00", {io_busy, io_fifo_dout_r});
    else pass_cnt++;
  endtask

  task automatic test_basic();
    int          done_k = 0;
    logic [31:0] exp;
    logic [31:0] words[3] = '{32'h11, 32'h22, 32'h33};
    @(negedge clock);
    foreach (words[i]) begin
      fifo_q.push_back(words[i]);
      exp_q.push_back(words[i]);
    end
    io_out_r = 1'b1;
    io_len   = 16'd3;
    io_start = 1'b1;
    for (int k = 1; k <= 40 && done_k == 0; k++) begin
      @(negedge clock);
      io_start = 1'b0;
      io_len   = 16'd7;
      if (k == 1) begin
        total_cnt++;
        if (io_fifo_dout_r !== 1'b1) $display("FAIL basic_first_req: got %b expected 1", io_fifo_dout_r);
        else pass_cnt++;
      end
      if (io_out_v && io_out_r) begin
        total_cnt++;
        if (exp_q.size() == 0) $display("FAIL basic_extra_word: got %h expected none", io_out_data);
        else begin
          exp = exp_q.pop_front();
          if (io_out_data !== exp) $display("FAIL basic_data: got %h expected %h", io_out_data, exp);
          else pass_cnt++;
        end
      end
      if (io_done) done_k = k;
    end
    total_cnt++;
    if (done_k != 10) $display("FAIL basic_done_cycle: got %0d expected 10", done_k);
    else pass_cnt++;
    total_cnt++;
    if (io_count !== 16'd3 || exp_q.size() != 0)
      $display("FAIL basic_count: got %0d (left %0d) expected 3 (left 0)", io_count, exp_q.size());
    else pass_cnt++;
    @(negedge clock);
    total_cnt++;
    if ({io_done, io_busy} !== 2'b00) $display("FAIL basic_done_pulse: done/busy %b expected 00", {io_done, io_busy});
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic        got_v = 1'b0;
    logic        done_seen = 1'b0;
    logic [51:0] obs;
    @(negedge clock);
    fifo_q.push_back(32'h77);
    fifo_q.push_back(32'h88);
    io_out_r = 1'b0;
    io_len   = 16'd2;
    io_start = 1'b1;
    for (int k = 0; k < 20 && !got_v; k++) begin
      @(negedge clock);
      io_start = 1'b0;
      got_v = io_out_v;
    end
    total_cnt++;
    if (!got_v) $display("FAIL rstmid_reach_out: got no io_out_v expected io_out_v");
    else pass_cnt++;
    #2 reset = 1'b0;
    #1 obs = {io_fifo_dout_r, io_out_v, io_busy, io_done, io_count, io_out_data};
    total_cnt++;
    if (obs !== '0) $display("FAIL rstmid_outputs: got %h expected 0", obs);
    else pass_cnt++;
    fifo_q.delete();
    exp_q.delete();
    repeat (2) begin
      @(negedge clock);
      done_seen |= io_done;
    end
    reset = 1'b1;
    repeat (2) begin
      @(negedge clock);
      done_seen |= io_done;
    end
    total_cnt++;
    if (done_seen || io_busy !== 1'b0)
      $display("FAIL rstmid_no_done: done_seen %b busy %b expected 0 0", done_seen, io_busy);
    else pass_cnt++;
  endtask

  task automatic test_empty_retry();
    logic [5:0]  pat = '0;
    logic        done_seen = 1'b0;
    logic [31:0] exp;
    @(negedge clock);
    exp_q.push_back(32'hA5);
    io_out_r = 1'b1;
    io_len   = 16'd1;
    io_start = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      io_start = 1'b0;
      pat = {pat[4:0], io_fifo_dout_r};
    end
    total_cnt++;
    if (pat !== 6'b101010) $display("FAIL empty_req_toggle: got %b expected 101010", pat);
    else pass_cnt++;
    fifo_q.push_back(32'hA5);
    for (int k = 0; k < 40 && !done_seen; k++) begin
      @(negedge clock);
      if (io_out_v && io_out_r) begin
        total_cnt++;
        if (exp_q.size() == 0) $display("FAIL empty_extra_word: got %h expected none", io_out_data);
        else begin
          exp = exp_q.pop_front();
          if (io_out_data !== exp) $display("FAIL empty_data: got %h expected %h", io_out_data, exp);
          else pass_cnt++;
        end
      end
      done_seen = io_done;
    end
    total_cnt++;
    if (!done_seen || io_count !== 16'd1 || exp_q.size() != 0)
      $display("FAIL empty_done: done %b count %0d left %0d expected 1 1 0", done_seen, io_count, exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic        got_v = 1'b0;
    logic        held_ok = 1'b1;
    logic        done_seen = 1'b0;
    int          r0;
    logic [31:0] exp;
    @(negedge clock);
    fifo_q.push_back(32'hDEADBEEF);
    fifo_q.push_back(32'h12345678);
    exp_q.push_back(32'hDEADBEEF);
    exp_q.push_back(32'h12345678);
    io_out_r = 1'b0;
    io_len   = 16'd2;
    io_start = 1'b1;
    for (int k = 0; k < 20 && !got_v; k++) begin
      @(negedge clock);
      io_start = 1'b0;
      got_v = io_out_v;
    end
    r0 = req_cnt;
    // A start pulse and a new length during the stall must be ignored.
    for (int k = 0; k < 5; k++) begin
      io_start = 1'b1;
      io_len   = 16'd5;
      @(negedge clock);
      held_ok &= (io_out_v === 1'b1) && (io_out_data === 32'hDEADBEEF);
    end
    io_start = 1'b0;
    total_cnt++;
    if (!got_v || !held_ok) $display("FAIL bp_hold: got_v %b held %b data %h expected 1 1 deadbeef", got_v, held_ok, io_out_data);
    else pass_cnt++;
    total_cnt++;
    if (req_cnt != r0) $display("FAIL bp_no_req: got %0d requests expected 0", req_cnt - r0);
    else pass_cnt++;
    io_out_r = 1'b1;
    for (int k = 0; k < 40 && !done_seen; k++) begin
      if (io_out_v && io_out_r) begin
        total_cnt++;
        if (exp_q.size() == 0) $display("FAIL bp_extra_word: got %h expected none", io_out_data);
        else begin
          exp = exp_q.pop_front();
          if (io_out_data !== exp) $display("FAIL bp_data: got %h expected %h", io_out_data, exp);
          else pass_cnt++;
        end
      end
      done_seen = io_done;
      if (!done_seen) @(negedge clock);
    end
    total_cnt++;
    if (!done_seen || io_count !== 16'd2 || exp_q.size() != 0)
      $display("FAIL bp_done: done %b count %0d left %0d expected 1 2 0", done_seen, io_count, exp_q.size());
    else pass_cnt++;
    @(negedge clock);
  endtask

  task automatic test_zero_len();
    int r0;
    @(negedge clock);
    r0 = req_cnt;
    io_len   = 16'd0;
    io_start = 1'b1;
    @(negedge clock);
    io_start = 1'b0;
    total_cnt++;
    if ({io_done, io_busy, io_fifo_dout_r} !== 3'b110 || io_count !== 16'd0)
      $display("FAIL zero_done: done/busy/req %b count %0d expected 110 0", {io_done, io_busy, io_fifo_dout_r}, io_count);
    else pass_cnt++;
    @(negedge clock);
    total_cnt++;
    if ({io_done, io_busy} !== 2'b00 || req_cnt != r0)
      $display("FAIL zero_idle: done/busy %b requests %0d expected 00 0", {io_done, io_busy}, req_cnt - r0);
    else pass_cnt++;
  endtask

`ifdef FIFO_DRAIN_SUM_EN
  task automatic test_sum();
    logic done_seen = 1'b0;
    @(negedge clock);
    fifo_q.push_back(32'hFFFFFFFF);
    fifo_q.push_back(32'h2);
    io_out_r = 1'b1;
    io_len   = 16'd2;
    io_start = 1'b1;
    for (int k = 0; k < 40 && !done_seen; k++) begin
      @(negedge clock);
      io_start = 1'b0;
      done_seen = io_done;
    end
    total_cnt++;
    if (!done_seen || io_sum !== 32'h00000001)
      $display("FAIL sum_at_done: done %b sum %h expected 1 00000001", done_seen, io_sum);
    else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_reset_mid();
    test_empty_retry();
    test_backpressure();
    test_zero_len();
`ifdef FIFO_DRAIN_SUM_EN
    test_sum();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
